axis_out_dw_keep: RTL



---
 rtl/axis_out_dw_keep.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/axis_out_dw_keep.sv
`default_nettype none
// ============================================================================
// Module   : axis_out_dw_keep
// Purpose  : AXI-Stream output down-converter with per-beat word masking.
//            Buffers one wide beat of S_WORDS words and emits it as
//            ceil(popcount(s_keep)/M_WORDS) narrow beats of M_WORDS words.
//            A beat with no kept words and no s_last is consumed silently.
//            A beat with no kept words and s_last emits one empty last beat.
// Ports    : aclk, rst          clock / synchronous active-high reset
//            s_valid/s_ready    wide input handshake
//            s_data/s_keep      input words (word 0 in LSBs), thermometer keep
//            s_last/s_user      end of packet / sideband
//            m_valid/m_ready    narrow output handshake
//            m_data/m_keep      output chunk words and per-word valid
//            m_last/m_user      end of packet / latched sideband
// Revision : 1.0 - initial release
// ============================================================================
module axis_out_dw_keep #(
    parameter int WORD_WIDTH = 32,
    parameter int S_WORDS    = 8,
    parameter int M_WORDS    = 2,
    parameter int USER_WIDTH = 8
) (
    input  logic                          aclk,
    input  logic                          rst,
    input  logic                          s_valid,
    output logic                          s_ready,
    input  logic [S_WORDS*WORD_WIDTH-1:0] s_data,
    input  logic [S_WORDS-1:0]            s_keep,
    input  logic                          s_last,
    input  logic [USER_WIDTH-1:0]         s_user,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic [M_WORDS*WORD_WIDTH-1:0] m_data,
    output logic [M_WORDS-1:0]            m_keep,
    output logic                          m_last,
    output logic [USER_WIDTH-1:0]         m_user
);

    localparam int c_CHUNKS = S_WORDS / M_WORDS;
    localparam int c_IDX_W  = (c_CHUNKS > 1) ? $clog2(c_CHUNKS) : 1;
    // One extra bit so that the chunk count can hold c_CHUNKS itself.
    localparam int c_CNT_W  = c_IDX_W + 1;
    localparam int c_POP_W  = $clog2(S_WORDS + 1);
    localparam int c_MW     = M_WORDS * WORD_WIDTH;

    generate
        if ((M_WORDS < 1) || (S_WORDS % M_WORDS != 0)) begin : g_ratio_check
            $error("axis_out_dw_keep: S_WORDS must be an integer multiple of M_WORDS");
        end
    endgenerate

    logic [S_WORDS*WORD_WIDTH-1:0] r_data;
    logic [S_WORDS-1:0]            r_keep;
    logic                          r_last;
    logic [USER_WIDTH-1:0]         r_user;
    logic                          r_full;
    logic [c_IDX_W-1:0]            r_idx;
    logic [c_CNT_W-1:0]            r_n_chunks;

    logic [c_POP_W-1:0]            w_pop;
    logic [c_CNT_W-1:0]            w_n_chunks;
    logic [c_CNT_W-1:0]            w_idx_ext;
    logic                          w_last_chunk;
    logic                          w_load;
    logic                          w_adv;
    logic [c_MW-1:0]               w_chunk_data;
    logic [M_WORDS-1:0]            w_chunk_keep;

    // Chunk count is popcount based, so a malformed (non-thermometer) keep
    // still yields a bounded number of output beats.
    always_comb begin
        w_pop = '0;
        for (int i = 0; i < S_WORDS; i++) begin
            w_pop = w_pop + c_POP_W'(s_keep[i]);
        end
    end

    always_comb begin
        w_n_chunks = '0;
        if (w_pop == '0) begin
            // An empty last beat still has to deliver the packet boundary.
            w_n_chunks = s_last ? c_CNT_W'(1) : '0;
        end else begin
            w_n_chunks = c_CNT_W'((int'(w_pop) + M_WORDS - 1) / M_WORDS);
        end
    end

    assign w_idx_ext    = {1'b0, r_idx};
    assign w_last_chunk = ((w_idx_ext + c_CNT_W'(1)) == r_n_chunks);

    // The final-chunk handshake frees the buffer in the same cycle, so the
    // next beat can load without a bubble.
    assign s_ready = ~rst & (~r_full | (m_ready & w_last_chunk));
    assign w_load  = s_valid & s_ready;
    assign w_adv   = r_full & m_ready;

    always_ff @(posedge aclk) begin
        if (rst) begin
            r_data     <= '0;
            r_keep     <= '0;
            r_last     <= 1'b0;
            r_user     <= '0;
            r_full     <= 1'b0;
            r_idx      <= '0;
            r_n_chunks <= '0;
        end else if (w_load) begin
            r_data     <= s_data;
            r_keep     <= s_keep;
            r_last     <= s_last;
            r_user     <= s_user;
            r_full     <= (w_n_chunks != '0);
            r_idx      <= '0;
            r_n_chunks <= w_n_chunks;
        end else if (w_adv) begin
            if (w_last_chunk) begin
                r_full <= 1'b0;
                r_idx  <= '0;
            end else begin
                r_idx  <= r_idx + c_IDX_W'(1);
            end
        end
    end

    generate
        if (c_CHUNKS == 1) begin : g_single
            assign w_chunk_data = r_data;
            assign w_chunk_keep = r_keep;
        end else begin : g_multi
            logic [c_MW-1:0]    w_data_arr [c_CHUNKS];
            logic [M_WORDS-1:0] w_keep_arr [c_CHUNKS];
            for (genvar g = 0; g < c_CHUNKS; g++) begin : g_chunk
                assign w_data_arr[g] = r_data[g*c_MW +: c_MW];
                assign w_keep_arr[g] = r_keep[g*M_WORDS +: M_WORDS];
            end
            assign w_chunk_data = w_data_arr[r_idx];
            assign w_chunk_keep = w_keep_arr[r_idx];
        end
    endgenerate

    assign m_valid = r_full;
    assign m_data  = w_chunk_data;
    assign m_keep  = w_chunk_keep;
    assign m_last  = r_full & r_last & w_last_chunk;
    assign m_user  = r_user;

endmodule
`default_nettype wire
